// File: rtl/shift_ram_ingress_arb.sv
// Ingress arbiter for the 11-channel shift RAM: round-robin grants one channel
// write per cycle and tags RAM read data once a channel's delay line is primed.
module shift_ram_ingress_arb #(
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [10:0]      ch_valid,
    input  logic [11*DW-1:0] ch_data,
    output logic [10:0]      ch_ready,
    input  logic             stall,
    input  logic             flush,
    output logic [10:0]      push,
    output logic [3:0]       sel,
    output logic [DW-1:0]    din,
    output logic             ram_re,
    output logic             out_valid,
    output logic [3:0]       out_chan,
    output logic [10:0]      primed
);

    localparam int unsigned NCH = 11;

    function automatic logic [7:0] depth(input int unsigned k);
        return 8'(17 * (k + 1));
    endfunction

    logic [3:0]    rr_q, rr_d;
    logic [10:0]   push_q, push_d;
    logic [3:0]    sel_q, sel_d;
    logic [DW-1:0] din_q, din_d;
    logic          ram_re_q, ram_re_d;
    logic [7:0]    cnt_q [NCH];
    logic [7:0]    cnt_d [NCH];
    logic [10:0]   primed_q, primed_d;
    logic          tag_v_q [RD_LAT+1];
    logic          tag_v_d [RD_LAT+1];
    logic [3:0]    tag_c_q [RD_LAT+1];
    logic [3:0]    tag_c_d [RD_LAT+1];

    logic [10:0]   grant;
    logic          found;
    logic [4:0]    scan;

    // First valid channel at or after rr, wrapping 10 -> 0.
    always_comb begin
        grant = '0;
        found = 1'b0;
        scan  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            scan = {1'b0, rr_q} + 5'(i);
            if (scan >= 5'(NCH)) begin
                scan = scan - 5'(NCH);
            end
            if (!found && ch_valid[scan[3:0]]) begin
                found             = 1'b1;
                grant[scan[3:0]]  = 1'b1;
            end
        end
        ch_ready = (stall || flush || !reset_n) ? '0 : grant;
    end

    always_comb begin
        rr_d     = rr_q;
        push_d   = '0;
        sel_d    = sel_q;
        din_d    = din_q;
        ram_re_d = 1'b0;
        cnt_d    = cnt_q;
        primed_d = '0;
        tag_v_d[0] = 1'b0;
        tag_c_d[0] = '0;

        for (int unsigned k = 0; k < NCH; k++) begin
            if (ch_valid[k] && ch_ready[k]) begin
                rr_d       = (k == NCH - 1) ? 4'd0 : 4'(k + 1);
                push_d[k]  = 1'b1;
                sel_d      = 4'(k);
                din_d      = ch_data[k*DW +: DW];
                ram_re_d   = 1'b1;
                // Tag reflects priming before this push is counted.
                tag_v_d[0] = primed_q[k];
                tag_c_d[0] = 4'(k);
                if (cnt_q[k] < depth(k)) begin
                    cnt_d[k] = cnt_q[k] + 8'd1;
                end
            end
        end

        if (flush) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                cnt_d[k] = '0;
            end
        end

        for (int unsigned k = 0; k < NCH; k++) begin
            primed_d[k] = (cnt_d[k] == depth(k));
        end

        for (int unsigned i = 1; i <= RD_LAT; i++) begin
            tag_v_d[i] = tag_v_q[i-1];
            tag_c_d[i] = tag_c_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q     <= '0;
            push_q   <= '0;
            sel_q    <= '0;
            din_q    <= '0;
            ram_re_q <= 1'b0;
            cnt_q    <= '{default: '0};
            primed_q <= '0;
            tag_v_q  <= '{default: 1'b0};
            tag_c_q  <= '{default: '0};
        end else begin
            rr_q     <= rr_d;
            push_q   <= push_d;
            sel_q    <= sel_d;
            din_q    <= din_d;
            ram_re_q <= ram_re_d;
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            tag_v_q  <= tag_v_d;
            tag_c_q  <= tag_c_d;
        end
    end

    assign push      = push_q;
    assign sel       = sel_q;
    assign din       = din_q;
    assign ram_re    = ram_re_q;
    assign primed    = primed_q;
    assign out_valid = tag_v_q[RD_LAT];
    assign out_chan  = tag_c_q[RD_LAT];

endmodule

// File: tb/tb_shift_ram_ingress_arb.sv
// Self-checking bench for shift_ram_ingress_arb: directed scenarios plus a
// randomized run against a push-counting reference model.
module tb_shift_ram_ingress_arb;

    localparam int DW     = 8;
    localparam int RD_LAT = 1;
    localparam int NCH    = 11;
    localparam int HIST   = 8192;

    logic              clk;
    logic              reset_n;
    logic [10:0]       ch_valid;
    logic [NCH*DW-1:0] ch_data;
    logic [10:0]       ch_ready;
    logic              stall;
    logic              flush;
    logic [10:0]       push;
    logic [3:0]        sel;
    logic [DW-1:0]     din;
    logic              ram_re;
    logic              out_valid;
    logic [3:0]        out_chan;
    logic [10:0]       primed;

    shift_ram_ingress_arb #(.DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_ready(ch_ready), .stall(stall), .flush(flush), .push(push),
        .sel(sel), .din(din), .ram_re(ram_re), .out_valid(out_valid),
        .out_chan(out_chan), .primed(primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: arbitration pointer, push counts since flush/reset,
    // expected registered outputs and a per-edge schedule of expected tags.
    int          m_rr;
    int          m_cnt [NCH];
    int          ecnt;
    bit          sched_v [HIST];
    int          sched_c [HIST];
    logic [10:0] e_ready, e_push, e_primed, obs_ready;
    int          e_sel;
    logic [DW-1:0] e_din;
    logic        e_re, e_ov;
    int          e_oc;

    function automatic int dep(input int k);
        return 17 * (k + 1);
    endfunction

    task automatic model_reset();
        m_rr = 0;
        for (int k = 0; k < NCH; k++) m_cnt[k] = 0;
        for (int i = 0; i < HIST; i++) begin
            sched_v[i] = 1'b0;
            sched_c[i] = 0;
        end
        e_push = '0; e_sel = 0; e_din = '0; e_re = 1'b0;
        e_primed = '0; e_ov = 1'b0; e_oc = 0;
    endtask

    task automatic apply_reset();
        reset_n  = 1'b0;
        ch_valid = '0;
        stall    = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    // Drives one cycle of inputs, captures ch_ready, advances the model.
    task automatic tick(input logic [10:0] v, input logic [NCH*DW-1:0] d,
                        input logic st, input logic fl);
        int k;
        ch_valid = v; ch_data = d; stall = st; flush = fl;
        #1;
        obs_ready = ch_ready;
        k = -1;
        if (!st && !fl) begin
            for (int i = 0; i < NCH; i++) begin
                if (k < 0 && v[(m_rr + i) % NCH]) k = (m_rr + i) % NCH;
            end
        end
        e_ready = (k >= 0) ? (11'(1) << k) : '0;
        @(posedge clk);
        ecnt++;
        if (k >= 0) begin
            if (ecnt + RD_LAT < HIST) begin
                sched_v[ecnt + RD_LAT] = (m_cnt[k] >= dep(k));
                sched_c[ecnt + RD_LAT] = k;
            end
            m_cnt[k]++;
            m_rr   = (k + 1) % NCH;
            e_push = 11'(1) << k;
            e_sel  = k;
            e_din  = d[k*DW +: DW];
            e_re   = 1'b1;
        end else begin
            e_push = '0;
            e_re   = 1'b0;
        end
        if (fl) for (int j = 0; j < NCH; j++) m_cnt[j] = 0;
        for (int j = 0; j < NCH; j++) e_primed[j] = (m_cnt[j] >= dep(j));
        e_ov = (ecnt < HIST) ? sched_v[ecnt] : 1'b0;
        e_oc = (ecnt < HIST) ? sched_c[ecnt] : 0;
        #1;
    endtask

    function automatic logic [NCH*DW-1:0] rnd_data();
        return (NCH*DW)'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(11'h7FF, rnd_data(), 1'b0, 1'b0);
        ch_valid = 11'h7FF;
        reset_n  = 1'b0;
        #1;
        checks++;
        if ({push, sel, din, ram_re, out_valid, out_chan, primed} !== '0) begin
            errors++;
            $display("FAIL reset_async_outputs: push=%h sel=%0d din=%h re=%b ov=%b oc=%0d primed=%h, required all 0",
                     push, sel, din, ram_re, out_valid, out_chan, primed);
        end
        checks++;
        if (ch_ready !== 11'h000) begin
            errors++;
            $display("FAIL reset_ready: ch_ready=%h required 000", ch_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({push, ram_re, out_valid, primed, ch_ready} !== '0) begin
            errors++;
            $display("FAIL reset_held: push=%h re=%b ov=%b primed=%h ready=%h, required 0",
                     push, ram_re, out_valid, primed, ch_ready);
        end
        reset_n = 1'b1;
        model_reset();
        tick(11'h7FF, rnd_data(), 1'b0, 1'b0);
        checks++;
        if (obs_ready !== 11'h001 || push !== 11'h001 || sel !== 4'd0) begin
            errors++;
            $display("FAIL reset_first_grant: ready=%h push=%h sel=%0d, required 001/001/0",
                     obs_ready, push, sel);
        end
    endtask

    task automatic test_single_priming();
        logic [NCH*DW-1:0] d;
        apply_reset();
        for (int i = 0; i < 17 + RD_LAT + 3; i++) begin
            d = rnd_data();
            d[DW-1:0] = DW'(i);
            tick(11'h001, d, 1'b0, 1'b0);
            checks++;
            if (obs_ready !== 11'h001 || push !== 11'h001 || sel !== 4'd0 || din !== DW'(i) || ram_re !== 1'b1) begin
                errors++;
                $display("FAIL prime_push[%0d]: ready=%h push=%h sel=%0d din=%0d re=%b, required 001/001/0/%0d/1",
                         i, obs_ready, push, sel, din, ram_re, i);
            end
            checks++;
            if (primed[0] !== (i >= 16)) begin
                errors++;
                $display("FAIL prime_flag[%0d]: primed0=%b required %b", i, primed[0], (i >= 16));
            end
            checks++;
            if (out_valid !== (i >= 17 + RD_LAT) || (out_valid === 1'b1 && out_chan !== 4'd0)) begin
                errors++;
                $display("FAIL prime_tag[%0d]: out_valid=%b out_chan=%0d required %b/0",
                         i, out_valid, out_chan, (i >= 17 + RD_LAT));
            end
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 13; i++) begin
            tick(11'h7FF, rnd_data(), 1'b0, 1'b0);
            checks++;
            if (sel !== 4'(i % NCH) || push !== (11'(1) << (i % NCH)) || ram_re !== 1'b1) begin
                errors++;
                $display("FAIL rr_seq[%0d]: sel=%0d push=%h re=%b required sel=%0d", i, sel, push, ram_re, i % NCH);
            end
        end
    endtask

    task automatic test_sparse();
        int exp_seq [3] = '{7, 3, 7};
        apply_reset();
        tick(11'h010, rnd_data(), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(11'h088, rnd_data(), 1'b0, 1'b0);
            checks++;
            if (sel !== 4'(exp_seq[i]) || push !== (11'(1) << exp_seq[i])) begin
                errors++;
                $display("FAIL sparse[%0d]: sel=%0d push=%h required sel=%0d", i, sel, push, exp_seq[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0]    held_sel;
        logic [DW-1:0] held_din;
        apply_reset();
        for (int i = 0; i < 4; i++) tick(11'h7FF, rnd_data(), 1'b0, 1'b0);
        held_sel = sel;
        held_din = din;
        for (int i = 0; i < 3; i++) begin
            tick(11'h7FF, rnd_data(), 1'b1, 1'b0);
            checks++;
            if (obs_ready !== 11'h000 || push !== 11'h000 || ram_re !== 1'b0 ||
                sel !== held_sel || din !== held_din) begin
                errors++;
                $display("FAIL stall[%0d]: ready=%h push=%h re=%b sel=%0d din=%h required 000/000/0/%0d/%h",
                         i, obs_ready, push, ram_re, sel, din, held_sel, held_din);
            end
        end
        tick(11'h7FF, rnd_data(), 1'b0, 1'b0);
        checks++;
        if (sel !== 4'd4 || push !== 11'h010) begin
            errors++;
            $display("FAIL stall_resume: sel=%0d push=%h required 4/010", sel, push);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 0; i < 17; i++) tick(11'h001, rnd_data(), 1'b0, 1'b0);
        checks++;
        if (primed[0] !== 1'b1) begin
            errors++;
            $display("FAIL flush_preprime: primed0=%b required 1", primed[0]);
        end
        tick(11'h001, rnd_data(), 1'b0, 1'b1);
        checks++;
        if (obs_ready !== 11'h000 || push !== 11'h000 || primed[0] !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: ready=%h push=%h primed0=%b required 000/000/0",
                     obs_ready, push, primed[0]);
        end
        for (int i = 0; i < 17 + RD_LAT + 2; i++) begin
            tick(11'h001, rnd_data(), 1'b0, 1'b0);
            checks++;
            if (out_valid !== (i >= 17 + RD_LAT)) begin
                errors++;
                $display("FAIL flush_reprime[%0d]: out_valid=%b required %b", i, out_valid, (i >= 17 + RD_LAT));
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] v;
        logic        st, fl;
        apply_reset();
        for (int c = 0; c < 2600; c++) begin
            if (c == 1900) apply_reset();
            if (c < 1300) v = 11'h700 | (11'($urandom()) & 11'($urandom()) & 11'($urandom()));
            else          v = 11'($urandom());
            st = ($urandom_range(9) == 0);
            fl = (c >= 1300) && ($urandom_range(149) == 0);
            tick(v, rnd_data(), st, fl);
            checks++;
            if (obs_ready !== e_ready || push !== e_push || sel !== 4'(e_sel) ||
                din !== e_din || ram_re !== e_re) begin
                errors++;
                $display("FAIL rand_drive[%0d]: ready=%h/%h push=%h/%h sel=%0d/%0d din=%h/%h re=%b/%b (got/required)",
                         c, obs_ready, e_ready, push, e_push, sel, e_sel, din, e_din, ram_re, e_re);
            end
            checks++;
            if (primed !== e_primed) begin
                errors++;
                $display("FAIL rand_primed[%0d]: primed=%h required %h", c, primed, e_primed);
            end
            checks++;
            if (out_valid !== e_ov || (e_ov && out_chan !== 4'(e_oc))) begin
                errors++;
                $display("FAIL rand_tag[%0d]: out_valid=%b out_chan=%0d required %b/%0d",
                         c, out_valid, out_chan, e_ov, e_oc);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        ecnt     = 0;
        ch_data  = '0;
        apply_reset();
        test_reset();
        test_single_priming();
        test_round_robin();
        test_sparse();
        test_stall();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_ram_ingress_arb.md
# shift_ram_ingress_arb

Ingress stage directly upstream of the 11-channel shift RAM (`fifo_shift_ram`). It accepts per-channel byte streams over valid/ready and round-robin arbitrates them down to one write per cycle. It drives the RAM's `push`/`sel`/`din`/`ram_re`. It tracks per-channel priming of each 17·(k+1)-deep delay line and tags RAM read data with `out_valid`/`out_chan` once that line holds real samples.

## Interface
Parameters:
- `DW`, 8, data width; must equal the RAM data width.
- `RD_LAT`, 1, RAM read latency in clocks from the `ram_re` edge to `dout` valid.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ch_valid`  in  11  per-channel data valid.
- `ch_data`  in  11·DW  packed; channel k occupies bits [k·DW +: DW].
- `ch_ready`  out  11  per-channel ready; at most one bit set.
- `stall`  in  1  back-pressure; blocks all grants while high.
- `flush`  in  1  synchronous; clears priming state.
- `push`  out  11  one-hot write strobe to the RAM.
- `sel`  out  4  encoded channel index, 0..10.
- `din`  out  DW  write data to the RAM.
- `ram_re`  out  1  RAM read enable.
- `out_valid`  out  1  RAM `dout` carries a real delayed sample this cycle.
- `out_chan`  out  4  channel index of that sample.
- `primed`  out  11  per-channel delay line full.

## Operation
- **Delay depth.** Channel k has depth D(k) = 17·(k+1): 17, 34, …, 187.
- **Write/read per push.** Each push to channel k writes one byte. It also reads the byte written D(k) pushes earlier, because read and write pointers coincide.
- **Arbiter pointer.** Round-robin pointer `rr` (4 bits, 0..10) holds the highest-priority channel.
- **Grant selection.** The grant goes to the first k with `ch_valid[k]` scanning rr, rr+1, …, wrapping 10→0.
- **Ready and transfer.** `ch_ready` = one-hot grant, forced to 0 when `stall`, `flush` or `!reset_n`. A transfer occurs when `ch_valid[k] & ch_ready[k]`.
- **Pointer update.** On a transfer to k, rr ← (k==10) ? 0 : k+1. With no transfer, rr holds.
- **Registered outputs.** On a transfer: `push` ← one-hot(k), `sel` ← k, `din` ← `ch_data[k]`, `ram_re` ← 1. With no transfer: `push` ← 0 and `ram_re` ← 0, while `sel` and `din` hold their last values so the RAM address stays stable.
- **Priming counters.** Each channel has an 8-bit `cnt[k]`.
  - On each push to k with `cnt[k]` < D(k), `cnt[k]` increments.
  - `primed[k]` = (`cnt[k]` == D(k)), registered.
- **Output tag.** The tag for each push is "`primed[k]` at push time", plus k. It enters an RD_LAT-deep pipeline whose output drives `out_valid`/`out_chan`.
- **Flush.**
  - All `cnt` and `primed` clear to 0; rr is unchanged.
  - No transfer occurs in the flush cycle.
  - Tags already in the pipeline still emerge.
  - RAM pointers are not touched, so D(k) fresh pushes are needed after a flush.
- **Reset values.** `push`=0, `sel`=0, `din`=0, `ram_re`=0, `out_valid`=0, `out_chan`=0, `primed`=0, rr=0, `cnt`=0, tag pipeline cleared. Reset mid-stream drops all in-flight tags.

## Timing
- **Accept (cycle T).** The handshake completes on edge E0 at the end of T.
- **Drive RAM (cycle T+1).** `push`, `sel`, `din` and `ram_re` are valid; the RAM writes and reads at E1.
- **Tag output (cycle T+1+RD_LAT).** `out_valid`/`out_chan` are asserted, aligned with RAM `dout`.
- **Throughput.** One transfer per cycle; no bubbles with continuous valid.
- **Stall.** A stall in cycle T yields `push`=0 in T+1; a stall of N cycles yields N idle RAM cycles.
- **Priming.** `primed[k]` rises the cycle after the D(k)-th push to k. The (D(k)+1)-th push to k is the first tagged `out_valid`.
- **Width.** `cnt` saturates at D(k) and never wraps. `sel` never exceeds 10.

## Test plan
- **Reset.** Assert `reset_n`=0 with all `ch_valid` high → all outputs 0 and `ch_ready`=0. Release → first grant to ch0 (rr=0).
- **Single-channel priming.** Hold `ch_valid`=11'h001 with `ch_data[7:0]`=0,1,2,… → `push`=11'h001 and `sel`=0 every cycle.
  - `primed[0]` rises after the 17th push.
  - The first `out_valid` (`out_chan`=0) accompanies the 18th push, RD_LAT cycles later, with `dout`=0.
  - The next sample has `dout`=1.
- **Full round-robin.** Hold `ch_valid`=11'h7FF → `sel` sequence 0,1,…,10,0,1, with `push` rotating one-hot each cycle.
- **Sparse priority.** rr=5 with only ch3 and ch7 valid → grant ch7, then ch3, then ch7.
- **Stall.** Stall for 3 cycles mid-stream → `ch_ready`=0 and `push`=0 for 3 cycles.
  - `sel`/`din` hold their values.
  - After release, the grant resumes at the held rr.
- **Flush.** Prime ch0, pulse `flush` with `ch_valid[0]`=1 → no transfer that cycle and `primed[0]`=0. The next 17 pushes to ch0 give no `out_valid`; the 18th does.
